// File: rtl/slice_serial_adder.sv
// slice_serial_adder: multi-cycle adder/subtractor that processes SLICE bits per clock, LSB slice first.
//   Parameters: WIDTH (operand/result width), SLICE (bits per cycle, must divide WIDTH).
//   Ports: clk, rst_n (async active-low); start_valid/start_ready accept a, b, cin, sub;
//          result_valid/result_ready hand off sum, cout, overflow, zero.
//   Optional macro SLICE_SERIAL_ADDER_FLAGS_EN builds the overflow and zero flags; otherwise both read 0.
module slice_serial_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    if (WIDTH < SLICE || WIDTH % SLICE != 0) begin : g_bad_params
        $error("slice_serial_adder: SLICE must divide WIDTH and WIDTH >= SLICE");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic              cout_q, cout_d;
    logic [31:0]       off;
    logic [SLICE:0]    slice_res;
    logic              last;

    assign off          = 32'(cnt_q) * 32'(SLICE);
    assign last         = cnt_q == CW'(N - 1);
    assign start_ready  = state_q == IDLE;
    assign result_valid = state_q == DONE;
    assign sum          = sum_q;
    assign cout         = cout_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        slice_res = {1'b0, a_q[off +: SLICE]} + {1'b0, b_q[off +: SLICE]} + {{SLICE{1'b0}}, carry_q};
        case (state_q)
            IDLE: if (start_valid) begin
                a_d     = a;
                // subtract is a + ~b + cin; the inversion is folded in at capture
                b_d     = b ^ {WIDTH{sub}};
                carry_d = cin;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                sum_d[off +: SLICE] = slice_res[SLICE-1:0];
                carry_d = slice_res[SLICE];
                cnt_d   = last ? '0 : cnt_q + CW'(1);
                if (last) begin
                    cout_d  = slice_res[SLICE];
                    state_d = DONE;
                end
            end
            DONE: if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

`ifdef SLICE_SERIAL_ADDER_FLAGS_EN
    logic ovf_q, ovf_d, zero_q, zero_d, msb_cin;

    // carry into the MSB recovered from the MSB sum bit of the final slice
    assign msb_cin = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_res[SLICE-1];

    always_comb begin
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (state_q == RUN && last) begin
            ovf_d  = msb_cin ^ slice_res[SLICE];
            zero_d = sum_d == '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign overflow = ovf_q;
    assign zero     = zero_q;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif
endmodule

// File: tb/tb_slice_serial_adder.sv
// tb_slice_serial_adder: randomized self-checking bench for slice_serial_adder (WIDTH=32, SLICE=4).
module tb_slice_serial_adder;
    localparam int N = 8;
`ifdef SLICE_SERIAL_ADDER_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic        clk = 0, rst_n = 1;
    logic        start_valid = 0, cin = 0, sub = 0, result_ready = 0;
    logic [31:0] a = 0, b = 0;
    logic        start_ready, result_valid, cout, overflow, zero;
    logic [31:0] sum;

    int n_cmp = 0, n_bad = 0;

    slice_serial_adder #(.WIDTH(32), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .result_valid(result_valid),
        .result_ready(result_ready), .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // {cout, overflow, zero, sum} from plain arithmetic
    function automatic logic [34:0] calc(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
        logic [31:0] yy;
        logic [32:0] full;
        logic        v;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {32'd0, ci};
        v    = (x[31] == yy[31]) && (full[31] != x[31]);
        return {full[32], FL & v, FL & (full[31:0] == 0), full[31:0]};
    endfunction

    // protocol-level reference: accepted op appears N edges later and stays until taken
    logic        m_idle = 1, m_valid = 0;
    int          m_wait = 0;
    logic [34:0] m_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle  <= 1;
            m_valid <= 0;
            m_wait  <= 0;
        end else if (m_idle) begin
            if (start_valid) begin
                m_res  <= calc(a, b, cin, sub);
                m_idle <= 0;
                m_wait <= N;
            end
        end else if (m_wait > 0) begin
            m_wait  <= m_wait - 1;
            m_valid <= m_wait == 1;
        end else if (result_ready) begin
            m_valid <= 0;
            m_idle  <= 1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst start_ready", 32'(start_ready), 1);
            chk("rst result_valid", 32'(result_valid), 0);
            chk("rst sum", sum, 0);
            chk("rst flags", {29'd0, cout, overflow, zero}, 0);
        end else begin
            chk("start_ready", 32'(start_ready), 32'(m_idle));
            chk("result_valid", 32'(result_valid), 32'(m_valid));
            if (m_valid) begin
                chk("sum", sum, m_res[31:0]);
                chk("cout", 32'(cout), 32'(m_res[34]));
                chk("overflow", 32'(overflow), 32'(m_res[33]));
                chk("zero", 32'(zero), 32'(m_res[32]));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input logic ci, input logic si,
                          input logic [31:0] es, input logic ec, input logic eo, input logic ez, input int hold);
        int lat;
        start_valid = 1; a = ai; b = bi; cin = ci; sub = si;
        tick;
        start_valid = 0; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!result_valid && lat < 3 * N) begin
            tick;
            lat++;
        end
        chk("latency", 32'(lat), N);
        chk("lit sum", sum, es);
        chk("lit cout", 32'(cout), 32'(ec));
        chk("lit overflow", 32'(overflow), 32'(FL & eo));
        chk("lit zero", 32'(zero), 32'(FL & ez));
        for (int i = 0; i < hold; i++) begin
            start_valid = 1'($urandom); a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            tick;
            chk("hold start_ready", 32'(start_ready), 0);
            chk("hold sum", sum, es);
        end
        start_valid  = 0;
        result_ready = 1;
        tick;
        result_ready = 0;
        chk("released start_ready", 32'(start_ready), 1);
        chk("released result_valid", 32'(result_valid), 0);
    endtask

    initial begin
        logic [34:0] r;
        logic [31:0] x, y;
        logic        c, s;
        #1 rst_n = 0;
        #1;
        chk("async rst ready", 32'(start_ready), 1);
        tick;
        tick;
        rst_n = 1;
        tick;
        run_op(32'h00000001, 32'hFFFFFFFF, 0, 0, 32'h00000000, 1, 0, 1, 0);
        run_op(32'd5, 32'd7, 1, 1, 32'hFFFFFFFE, 0, 0, 0, 0);
        run_op(32'd7, 32'd5, 1, 1, 32'h00000002, 1, 0, 0, 0);
        run_op(32'h7FFFFFFF, 32'd1, 0, 0, 32'h80000000, 0, 1, 0, 0);
        run_op(32'hFFFFFFFF, 32'd0, 1, 0, 32'h00000000, 1, 0, 1, 0);
        run_op(32'd0, 32'd0, 0, 0, 32'h00000000, 0, 0, 1, 0);
        run_op(32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1, 1, 5);
        // reset in the third RUN cycle
        start_valid = 1; a = 32'hDEADBEEF; b = 32'h01234567; cin = 0; sub = 0;
        tick;
        start_valid = 0;
        tick;
        tick;
        rst_n = 0;
        #1;
        chk("midrun rst ready", 32'(start_ready), 1);
        chk("midrun rst valid", 32'(result_valid), 0);
        chk("midrun rst sum", sum, 0);
        chk("midrun rst flags", {29'd0, cout, overflow, zero}, 0);
        tick;
        rst_n = 1;
        tick;
        run_op(32'h12345678, 32'h11111111, 0, 0, 32'h23456789, 0, 0, 0, 0);
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: x = 32'h7FFFFFFF;
                1: x = 32'h80000000;
                default: x = $urandom;
            endcase
            y = ($urandom_range(0, 3) == 0) ? x : $urandom;
            c = 1'($urandom);
            s = 1'($urandom);
            r = calc(x, y, c, s);
            run_op(x, y, c, s, r[31:0], r[34], r[33], r[32], $urandom_range(0, 3));
        end
        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/slice_serial_adder.md
Name: slice_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Adds WIDTH-bit operands SLICE bits per clock, LSB slice first, with the carry held in a register between slices.
- Generalises the 4-bit ripple full-adder building block:
  - width and slice size are parameters;
  - carry-in is honoured;
  - subtract mode;
  - valid/ready handshakes;
  - signed-overflow and zero flags.
- Sits in the ALU as the area-cheap path for wide or multi-word arithmetic, where a full-width single-cycle adder is too costly.

Parameters:
- WIDTH, 32, operand and result width in bits; must be >= SLICE.
- SLICE, 4, bits processed per cycle; must divide WIDTH exactly. A violation is an elaboration-time error.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  operands and mode are valid.
- start_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (in subtract mode, the inverted borrow-in).
- sub  input  1  0: a+b+cin; 1: a+~b+cin.
- result_valid  output  1  result outputs are valid.
- result_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values (rst_n low):
  - state = IDLE; slice counter = 0; carry register = 0.
  - sum = 0, cout = 0, overflow = 0, zero = 0, result_valid = 0.
  - start_ready = 1, decoded from IDLE. Handshakes while rst_n is low are ignored.
- N = WIDTH/SLICE. FSM states are IDLE, RUN and DONE.
- IDLE:
  - start_ready = 1.
  - On a clock edge with start_valid=1, the block:
    - captures a;
    - captures b XOR {WIDTH{sub}};
    - loads carry register = cin;
    - clears the counter;
    - goes to RUN.
  - Input ports are not sampled again until the next acceptance.
- RUN:
  - start_ready = 0. One slice per edge, slice k = counter.
  - Slice result = a_slice + b_slice + carry. It writes sum bits [k*SLICE +: SLICE] and updates the carry register.
  - On the last slice (k = N-1):
    - cout = final carry;
    - overflow = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1);
    - zero = (completed sum == 0), computed on the full registered result.
    - State goes to DONE.
- Latency: result_valid rises exactly N cycles after the acceptance edge. With N=1 (SLICE=WIDTH), RUN lasts one cycle.
- DONE:
  - result_valid = 1. sum, cout, overflow and zero are held stable until accepted.
  - On an edge with result_ready=1: result_valid falls and state returns to IDLE.
  - No same-cycle restart: the minimum issue interval is N+2 cycles.
  - start_valid has no effect outside IDLE.
- Result outputs keep their last values in IDLE; they are only meaningful while result_valid=1.
- Carry never leaks between operations: each acceptance reloads the carry from cin.
- Reset mid-operation (RUN or DONE): immediate return to reset values. The partial result is discarded and no result_valid pulse is produced.
- Subtract: a-b is sub=1 with cin=1. For multi-word subtraction, pass the previous word's cout as cin.

Optional Feature:
- Macro: SLICE_SERIAL_ADDER_FLAGS_EN.
- Defined: overflow and zero are computed as described above.
- Undefined:
  - overflow and zero are tied to 0;
  - the MSB carry-in tracking and the zero-detect logic are not built;
  - sum, cout, latency and handshake timing are unchanged.

Test Plan (WIDTH=32, SLICE=4, N=8):
- a=0x00000001, b=0xFFFFFFFF, cin=0, sub=0 -> result_valid exactly 8 cycles after the accept edge; sum=0x00000000, cout=1, zero=1, overflow=0.
- a=5, b=7, cin=1, sub=1 -> sum=0xFFFFFFFE, cout=0, overflow=0, zero=0. Then a=7, b=5 -> sum=2, cout=1.
- a=0x7FFFFFFF, b=1, cin=0, sub=0 -> sum=0x80000000, overflow=1, cout=0. With the macro undefined, the same stimulus gives overflow=0 and identical sum.
- a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1. Back-to-back second op with cin=0, a=b=0 -> sum=0, cout=0, confirming no carry carry-over.
- Hold result_ready=0 for 5 cycles in DONE while toggling start_valid and the operands -> sum and flags stable, start_ready=0, nothing accepted. Then result_ready=1 -> IDLE next cycle, start_ready=1.
- Assert rst_n low at the 3rd RUN cycle -> all outputs 0 asynchronously and start_ready=1. After release, a=0x12345678, b=0x11111111 -> sum=0x23456789 after 8 cycles.
